// File: rtl/datapath_seq_if.sv
// Handshake and data bus between a controller (master) and the datapath_seq
// sequencing datapath (slave): start controls and seeds in, working registers and flags out.
interface datapath_seq_if #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 8
);
  logic             START;
  logic [1:0]       MODE;
  logic             SAT;
  logic             Cin;
  logic [CNTW-1:0]  STEPS;
  logic [WIDTH-1:0] M0;
  logic [WIDTH-1:0] M1;
  logic [WIDTH-1:0] M2;
  logic [WIDTH-1:0] R0;
  logic [WIDTH-1:0] R1;
  logic [WIDTH-1:0] R2;
  logic             COUT;
  logic             OVF;
  logic             BUSY;
  logic             DONE;

  modport master (
    output START, MODE, SAT, Cin, STEPS, M0, M1, M2,
    input  R0, R1, R2, COUT, OVF, BUSY, DONE
  );

  modport slave (
    input  START, MODE, SAT, Cin, STEPS, M0, M1, M2,
    output R0, R1, R2, COUT, OVF, BUSY, DONE
  );
endinterface

// File: rtl/datapath_seq.sv
// Three-register add/subtract sequencing datapath with an IDLE/RUN/DONE controller;
// seeds load on START, then STEPS arithmetic steps run in the latched mode.
module datapath_seq #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 8
) (
  input logic           CLK,
  input logic           SW1,
  datapath_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [1:0]       MODE_ADD = 2'b00;
  localparam logic [1:0]       MODE_SUB = 2'b01;
  localparam logic [1:0]       MODE_ACC = 2'b10;
  localparam logic [1:0]       MODE_ROT = 2'b11;
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [CNTW-1:0]  CNT_ZERO = {CNTW{1'b0}};
  localparam logic [CNTW-1:0]  CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] r0_r, r1_r, r2_r;
  logic             cout_r, ovf_r, busy_r, done_r;
  logic [CNTW-1:0]  counter_r;
  logic [1:0]       mode_r;
  logic             sat_r, cin_r;
  logic [CNTW-1:0]  steps_r;

  logic [WIDTH:0]   cin_ext_s;
  logic [WIDTH:0]   sum_s;
  logic             carry_s;
  logic [WIDTH-1:0] res_s;
  logic [WIDTH-1:0] n0_s, n1_s, n2_s;
  logic             last_step_s;

  // One arithmetic step: WIDTH+1 bit sum/difference, carry or borrow, saturation and shuffle
  always_comb begin
    cin_ext_s = {{WIDTH{1'b0}}, cin_r};
    sum_s     = {(WIDTH+1){1'b0}};
    carry_s   = 1'b0;
    res_s     = ZERO_W;
    n0_s      = r0_r;
    n1_s      = r1_r;
    n2_s      = r2_r;
    case (mode_r)
      MODE_ADD: begin
        sum_s   = {1'b0, r0_r} + {1'b0, r1_r} + cin_ext_s;
        carry_s = sum_s[WIDTH];
        res_s   = (sat_r && carry_s) ? ALL_ONES : sum_s[WIDTH-1:0];
        n0_s    = r1_r;
        n1_s    = res_s;
        n2_s    = res_s;
      end
      MODE_SUB: begin
        // The top bit of the two's complement difference is exactly the borrow
        sum_s   = {1'b0, r1_r} - {1'b0, r0_r} - cin_ext_s;
        carry_s = sum_s[WIDTH];
        res_s   = (sat_r && carry_s) ? ZERO_W : sum_s[WIDTH-1:0];
        n0_s    = r1_r;
        n1_s    = res_s;
        n2_s    = res_s;
      end
      MODE_ACC: begin
        sum_s   = {1'b0, r2_r} + {1'b0, r0_r} + cin_ext_s;
        carry_s = sum_s[WIDTH];
        res_s   = (sat_r && carry_s) ? ALL_ONES : sum_s[WIDTH-1:0];
        n2_s    = res_s;
      end
      MODE_ROT: begin
        n0_s = r1_r;
        n1_s = r2_r;
        n2_s = r0_r;
      end
      default: begin
        n0_s = r0_r;
      end
    endcase
  end

  assign last_step_s = (counter_r == (steps_r - CNT_ONE));

  // Controller next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.START) begin
          state_next_s = (bus.STEPS != CNT_ZERO) ? ST_RUN : ST_DONE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_step_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Controller state register
  always_ff @(posedge CLK) begin
    if (SW1) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Working registers, latched controls, counter and flags
  always_ff @(posedge CLK) begin
    if (SW1) begin
      r0_r      <= ZERO_W;
      r1_r      <= ZERO_W;
      r2_r      <= ZERO_W;
      cout_r    <= 1'b0;
      ovf_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      counter_r <= CNT_ZERO;
      mode_r    <= 2'b00;
      sat_r     <= 1'b0;
      cin_r     <= 1'b0;
      steps_r   <= CNT_ZERO;
    end else begin
      // BUSY/DONE follow the state being entered so they stay registered outputs
      busy_r <= (state_next_s == ST_RUN);
      done_r <= (state_next_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (bus.START) begin
            r0_r      <= bus.M0;
            r1_r      <= bus.M1;
            r2_r      <= bus.M2;
            mode_r    <= bus.MODE;
            sat_r     <= bus.SAT;
            cin_r     <= bus.Cin;
            steps_r   <= bus.STEPS;
            cout_r    <= 1'b0;
            ovf_r     <= 1'b0;
            counter_r <= CNT_ZERO;
          end else begin
            r0_r <= r0_r;
          end
        end
        ST_RUN: begin
          r0_r      <= n0_s;
          r1_r      <= n1_s;
          r2_r      <= n2_s;
          cout_r    <= carry_s;
          ovf_r     <= ovf_r | carry_s;
          counter_r <= counter_r + CNT_ONE;
        end
        default: begin
          r0_r <= r0_r;
        end
      endcase
    end
  end

  assign bus.R0   = r0_r;
  assign bus.R1   = r1_r;
  assign bus.R2   = r2_r;
  assign bus.COUT = cout_r;
  assign bus.OVF  = ovf_r;
  assign bus.BUSY = busy_r;
  assign bus.DONE = done_r;

endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq: a run-level reference model predicts every output cycle,
// and hand-computed literals pin key points of each scenario.
module tb_datapath_seq;
  localparam int WIDTH = 4;
  localparam int CNTW  = 8;

  logic CLK = 1'b0;
  logic SW1;
  always #5 CLK = ~CLK;

  datapath_seq_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();
  datapath_seq #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (.CLK(CLK), .SW1(SW1), .bus(bus));

  typedef struct packed {
    logic [WIDTH-1:0] r0, r1, r2;
    logic cout, ovf, busy, done;
  } obs_t;

  obs_t cur;
  obs_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   checking = 1'b0;

  function automatic obs_t mk(int a, int b, int c, bit co, bit ov, bit bu, bit dn);
    obs_t o;
    o.r0 = WIDTH'(a); o.r1 = WIDTH'(b); o.r2 = WIDTH'(c);
    o.cout = co; o.ovf = ov; o.busy = bu; o.done = dn;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(int'(bus.R0), int'(bus.R1), int'(bus.R2), bus.COUT, bus.OVF, bus.BUSY, bus.DONE);
  endfunction

  // Precompute the whole output trajectory of a run from the latched start values
  task automatic build_run();
    int r0, r1, r2, m, sat, cin, steps, s, res, t;
    int lim;
    bit c, ovf;
    lim = 1 << WIDTH;
    r0 = int'(bus.M0); r1 = int'(bus.M1); r2 = int'(bus.M2);
    m = int'(bus.MODE); sat = int'(bus.SAT); cin = int'(bus.Cin); steps = int'(bus.STEPS);
    c = 1'b0; ovf = 1'b0;
    cur = mk(r0, r1, r2, 1'b0, 1'b0, steps != 0, steps == 0);
    for (int i = 1; i <= steps; i++) begin
      case (m)
        0: begin
          s = r0 + r1 + cin; c = (s >= lim);
          res = (sat != 0 && c) ? lim - 1 : s % lim;
          r0 = r1; r1 = res; r2 = res;
        end
        1: begin
          c = (r1 < r0 + cin); s = r1 - r0 - cin;
          res = (sat != 0 && c) ? 0 : (s + lim) % lim;
          r0 = r1; r1 = res; r2 = res;
        end
        2: begin
          s = r2 + r0 + cin; c = (s >= lim);
          res = (sat != 0 && c) ? lim - 1 : s % lim;
          r2 = res;
        end
        default: begin
          t = r0; r0 = r1; r1 = r2; r2 = t; c = 1'b0;
        end
      endcase
      ovf = ovf | c;
      q.push_back(mk(r0, r1, r2, c, ovf, i < steps, i == steps));
    end
    q.push_back(mk(r0, r1, r2, c, ovf, 1'b0, 1'b0));
  endtask

  always @(posedge CLK) begin
    if (SW1) begin
      cur = '0;
      q.delete();
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else if (bus.START) begin
      build_run();
    end
  end

  always @(negedge CLK) begin
    if (checking) begin
      obs_t act;
      act = sample();
      vectors++;
      if (act !== cur) begin
        miscompares++;
        $display("FAIL model_cycle t=%0t got R=%0d,%0d,%0d C=%b O=%b B=%b D=%b expected R=%0d,%0d,%0d C=%b O=%b B=%b D=%b",
                 $time, act.r0, act.r1, act.r2, act.cout, act.ovf, act.busy, act.done,
                 cur.r0, cur.r1, cur.r2, cur.cout, cur.ovf, cur.busy, cur.done);
      end
    end
  end

  task automatic lit(string nm, int e0, int e1, int e2, bit ec, bit eo, bit eb, bit ed);
    obs_t act, exp;
    act = sample();
    exp = mk(e0, e1, e2, ec, eo, eb, ed);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got R=%0d,%0d,%0d C=%b O=%b B=%b D=%b expected R=%0d,%0d,%0d C=%b O=%b B=%b D=%b",
               nm, act.r0, act.r1, act.r2, act.cout, act.ovf, act.busy, act.done,
               exp.r0, exp.r1, exp.r2, exp.cout, exp.ovf, exp.busy, exp.done);
    end
  endtask

  task automatic run(int mode, int sat, int cin, int steps, int m0, int m1, int m2);
    @(posedge CLK); #2;
    bus.MODE = 2'(mode); bus.SAT = 1'(sat); bus.Cin = 1'(cin); bus.STEPS = CNTW'(steps);
    bus.M0 = WIDTH'(m0); bus.M1 = WIDTH'(m1); bus.M2 = WIDTH'(m2);
    bus.START = 1'b1;
    @(posedge CLK); #2;
    bus.START = 1'b0;
    // Scramble inputs after the start edge; the run must not notice
    bus.M0 = ~bus.M0; bus.M1 = ~bus.M1; bus.M2 = ~bus.M2;
    bus.MODE = ~bus.MODE; bus.SAT = ~bus.SAT; bus.Cin = ~bus.Cin; bus.STEPS = 8'd1;
  endtask

  task automatic wait_done(int budget);
    int n;
    n = 0;
    while (bus.DONE !== 1'b1 && n < budget) begin
      @(negedge CLK); #1;
      n++;
    end
    vectors++;
    if (bus.DONE !== 1'b1) begin
      miscompares++;
      $display("FAIL done_timeout got DONE=%b after %0d cycles expected DONE=1", bus.DONE, n);
    end
  endtask

  initial begin
    SW1 = 1'b1;
    bus.START = 1'b1; bus.MODE = 2'b00; bus.SAT = 1'b0; bus.Cin = 1'b1; bus.STEPS = 8'd5;
    bus.M0 = 4'd5; bus.M1 = 4'd6; bus.M2 = 4'd7;
    @(posedge CLK); #1;
    checking = 1'b1;
    @(negedge CLK); #1; lit("reset", 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    #2; SW1 = 1'b0; bus.START = 1'b0;
    repeat (2) @(negedge CLK);
    #1; lit("post_reset", 0, 0, 0, 0, 0, 0, 0);

    // ADD wrap
    run(0, 0, 0, 3, 1, 7, 0);
    @(negedge CLK); #1; lit("add_seed", 1, 7, 0, 0, 0, 1, 0);
    @(negedge CLK); #1; lit("add_s1", 7, 8, 8, 0, 0, 1, 0);
    @(negedge CLK); #1; lit("add_s2", 8, 15, 15, 0, 0, 1, 0);
    @(negedge CLK); #1; lit("add_s3", 15, 7, 7, 1, 1, 0, 1);
    @(negedge CLK); #1; lit("add_idle", 15, 7, 7, 1, 1, 0, 0);

    // ADD saturate
    run(0, 1, 0, 3, 1, 7, 0);
    repeat (4) @(negedge CLK);
    #1; lit("add_sat_s3", 15, 15, 15, 1, 1, 0, 1);

    // SUB then ACC
    run(1, 0, 1, 1, 3, 10, 0);
    repeat (2) @(negedge CLK);
    #1; lit("sub_s1", 10, 6, 6, 0, 0, 0, 1);
    run(2, 0, 0, 2, 5, 9, 14);
    repeat (2) @(negedge CLK);
    #1; lit("acc_s1", 5, 9, 3, 1, 1, 1, 0);
    @(negedge CLK); #1; lit("acc_s2", 5, 9, 8, 0, 1, 0, 1);

    // STEPS=0
    run(0, 0, 1, 0, 9, 4, 2);
    @(negedge CLK); #1; lit("zero_steps", 9, 4, 2, 0, 0, 0, 1);
    @(negedge CLK); #1; lit("zero_idle", 9, 4, 2, 0, 0, 0, 0);

    // START during RUN is ignored
    run(0, 0, 1, 5, 2, 3, 4);
    @(negedge CLK); #1; bus.START = 1'b1;
    repeat (2) @(negedge CLK);
    #1; bus.START = 1'b0;
    wait_done(10);
    lit("restart_ignored", 12, 14, 14, 0, 1, 0, 1);

    // ROT returns to seeds after 3 steps
    run(3, 1, 1, 3, 1, 2, 3);
    repeat (2) @(negedge CLK);
    #1; lit("rot_s1", 2, 3, 1, 0, 0, 1, 0);
    repeat (2) @(negedge CLK);
    #1; lit("rot_s3", 1, 2, 3, 0, 0, 0, 1);

    // Full-count run, counter must not wrap
    run(3, 0, 0, 255, 1, 2, 3);
    wait_done(300);
    lit("rot_255", 1, 2, 3, 0, 0, 0, 1);

    // Reset mid-run abandons the run
    run(0, 0, 0, 10, 1, 1, 0);
    repeat (5) @(negedge CLK);
    #1; lit("mid_s4", 5, 8, 8, 0, 0, 1, 0);
    SW1 = 1'b1; bus.START = 1'b1;
    @(negedge CLK); #1; lit("mid_reset", 0, 0, 0, 0, 0, 0, 0);
    SW1 = 1'b0; bus.START = 1'b0;
    repeat (3) @(negedge CLK);
    #1; lit("mid_no_done", 0, 0, 0, 0, 0, 0, 0);
    run(0, 0, 0, 2, 2, 3, 0);
    repeat (2) @(negedge CLK);
    #1; lit("after_reset_s1", 3, 5, 5, 0, 0, 1, 0);
    @(negedge CLK); #1; lit("after_reset_s2", 5, 8, 8, 0, 0, 0, 1);

    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
